// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types: register-file geometry and the long-latency FIFO entry.
package writeback_arbiter_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Register-file write port bundle: pipeline and long-latency producers in, write port and interlock out.
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_reg;
    logic [DATA_W-1:0]   wb_data;
    logic                lu_valid;
    logic [ADDR_W-1:0]   lu_reg;
    logic [DATA_W-1:0]   lu_data;
    logic                lu_ready;
    logic                RegWrite;
    logic [ADDR_W-1:0]   WriteReg;
    logic [DATA_W-1:0]   WriteData;
    logic                stall_req;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
        input  lu_ready, RegWrite, WriteReg, WriteData, stall_req, busy_mask
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
        output lu_ready, RegWrite, WriteReg, WriteData, stall_req, busy_mask
    );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Circular buffer of long-latency results; each entry carries a live bit that a
// younger pipeline write to the same register can clear in place.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  wb_entry_t           pushEntry,
    input  logic                pop,
    input  logic                squash,
    input  logic [ADDR_W-1:0]   squashReg,
    output wb_entry_t           head,
    output logic                empty,
    output logic                full,
    output logic [NUM_REGS-1:0] liveMask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i].live <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (squash && mem[i].live && (mem[i].dest == squashReg)) mem[i].live <= 1'b0;
            end
            // Retired slots drop their live bit so liveMask only sees occupied entries.
            if (pop) begin
                mem[rdPtr].live <= 1'b0;
                rdPtr           <= rdPtr + PTR_W'(1);
            end
            if (push) begin
                mem[wrPtr] <= pushEntry;
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rdPtr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_comb begin
        liveMask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem[i].live) liveMask[mem[i].dest] = 1'b1;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port producer: pipeline results win, queued long-latency
// results fill idle slots, and a starving FIFO head requests a pipeline bubble.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic               clk,
    input logic               rst,
    writeback_arbiter_if.slave bus
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t           head;
    wb_entry_t           pushEntry;
    logic                fifoEmpty;
    logic                fifoFull;
    logic [NUM_REGS-1:0] liveMask;
    logic [WAIT_W-1:0]   waitCnt;
    logic [WAIT_W-1:0]   waitNext;
    logic                stallNext;
    logic                wbWrite;
    logic                headLive;
    logic                popLive;
    logic                pop;
    logic                push;
    logic                headSurvives;

    always_comb begin
        wbWrite   = bus.wb_valid && (bus.wb_reg != '0);
        headLive  = !fifoEmpty && head.live;
        popLive   = headLive && !wbWrite;
        pop       = popLive || (!fifoEmpty && !head.live);
        // A same-cycle pipeline write to lu_reg makes the queued value stale on arrival.
        push      = bus.lu_valid && bus.lu_ready && (bus.lu_reg != '0)
                    && !(wbWrite && (bus.wb_reg == bus.lu_reg));
        pushEntry = '{live: 1'b1, dest: bus.lu_reg, data: bus.lu_data};

        headSurvives = headLive && !pop && !(wbWrite && (head.dest == bus.wb_reg));
        waitNext     = '0;
        if (headSurvives) begin
            waitNext = (waitCnt == WAIT_W'(STARVE_LIMIT)) ? waitCnt : waitCnt + WAIT_W'(1);
        end

        stallNext = bus.stall_req;
        if (pop) stallNext = 1'b0;
        if (waitNext == WAIT_W'(STARVE_LIMIT)) stallNext = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RegWrite  <= 1'b0;
            bus.WriteReg  <= '0;
            bus.WriteData <= '0;
            bus.stall_req <= 1'b0;
            waitCnt       <= '0;
        end else begin
            bus.RegWrite  <= wbWrite || popLive;
            if (wbWrite) begin
                bus.WriteReg  <= bus.wb_reg;
                bus.WriteData <= bus.wb_data;
            end else if (popLive) begin
                bus.WriteReg  <= head.dest;
                bus.WriteData <= head.data;
            end
            bus.stall_req <= stallNext;
            waitCnt       <= waitNext;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pushEntry (pushEntry),
        .pop       (pop),
        .squash    (wbWrite),
        .squashReg (bus.wb_reg),
        .head      (head),
        .empty     (fifoEmpty),
        .full      (fifoFull),
        .liveMask  (liveMask)
    );

    assign bus.lu_ready  = !fifoFull && !rst;
    assign bus.busy_mask = liveMask;

    noWbDuringStall: assert property (@(posedge clk) disable iff (rst)
        !(bus.stall_req && bus.wb_valid));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed checks of writeback_arbiter priority, squash, starvation stall, FIFO flow and reset.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   vecCnt;
    int   errCnt;

    writeback_arbiter_if bus ();

    writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drvWb(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.wb_valid = v;
        bus.wb_reg   = r;
        bus.wb_data  = d;
    endtask

    task automatic drvLu(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.lu_valid = v;
        bus.lu_reg   = r;
        bus.lu_data  = d;
    endtask

    initial begin
        vecCnt = 0;
        errCnt = 0;
        rst    = 1'b1;
        drvWb(1'b0, '0, '0);
        drvLu(1'b0, '0, '0);
        repeat (2) tick();

        // Reset state
        chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_writereg", 64'(bus.WriteReg), 64'd0);
        chk("rst_writedata", 64'(bus.WriteData), 64'd0);
        chk("rst_stall", 64'(bus.stall_req), 64'd0);
        chk("rst_busy", 64'(bus.busy_mask), 64'd0);
        chk("rst_ready_low", 64'(bus.lu_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(bus.lu_ready), 64'd1);

        // 1: plain pipeline write
        drvWb(1'b1, 5'd8, 32'hDEAD_BEEF);
        tick();
        drvWb(1'b0, '0, '0);
        chk("t1_regwrite", 64'(bus.RegWrite), 64'd1);
        chk("t1_writereg", 64'(bus.WriteReg), 64'd8);
        chk("t1_writedata", 64'(bus.WriteData), 64'hDEAD_BEEF);
        tick();
        chk("t1_idle", 64'(bus.RegWrite), 64'd0);
        chk("t1_hold_reg", 64'(bus.WriteReg), 64'd8);

        // 2: long-latency result drains into an idle slot
        drvLu(1'b1, 5'd3, 32'h55);
        tick();
        drvLu(1'b0, '0, '0);
        chk("t2_busy_set", 64'(bus.busy_mask), 64'h8);
        chk("t2_no_write_yet", 64'(bus.RegWrite), 64'd0);
        tick();
        chk("t2_regwrite", 64'(bus.RegWrite), 64'd1);
        chk("t2_writereg", 64'(bus.WriteReg), 64'd3);
        chk("t2_writedata", 64'(bus.WriteData), 64'h55);
        chk("t2_busy_clr", 64'(bus.busy_mask), 64'd0);

        // 3: starvation raises stall_req after three lost cycles
        drvLu(1'b1, 5'd4, 32'h44);
        drvWb(1'b1, 5'd9, 32'h99);
        tick();
        drvLu(1'b0, '0, '0);
        chk("t3_busy", 64'(bus.busy_mask), 64'h10);
        chk("t3_wb_wins", 64'(bus.WriteReg), 64'd9);
        chk("t3_stall_e0", 64'(bus.stall_req), 64'd0);
        tick();
        chk("t3_stall_e1", 64'(bus.stall_req), 64'd0);
        tick();
        chk("t3_stall_e2", 64'(bus.stall_req), 64'd0);
        tick();
        chk("t3_stall_e3", 64'(bus.stall_req), 64'd1);
        chk("t3_busy_held", 64'(bus.busy_mask), 64'h10);
        drvWb(1'b0, '0, '0);
        tick();
        chk("t3_regwrite", 64'(bus.RegWrite), 64'd1);
        chk("t3_writereg", 64'(bus.WriteReg), 64'd4);
        chk("t3_writedata", 64'(bus.WriteData), 64'h44);
        chk("t3_stall_clr", 64'(bus.stall_req), 64'd0);
        chk("t3_busy_clr", 64'(bus.busy_mask), 64'd0);

        // 4: younger pipeline write squashes the queued entry
        drvLu(1'b1, 5'd5, 32'h5A);
        drvWb(1'b1, 5'd10, 32'hA0);
        tick();
        drvLu(1'b0, '0, '0);
        chk("t4_busy_set", 64'(bus.busy_mask), 64'h20);
        drvWb(1'b1, 5'd5, 32'h500);
        tick();
        drvWb(1'b0, '0, '0);
        chk("t4_busy_squash", 64'(bus.busy_mask), 64'd0);
        chk("t4_wb_reg", 64'(bus.WriteReg), 64'd5);
        chk("t4_wb_data", 64'(bus.WriteData), 64'h500);
        tick();
        chk("t4_dead_pop_nowrite", 64'(bus.RegWrite), 64'd0);
        chk("t4_data_held", 64'(bus.WriteData), 64'h500);
        tick();
        chk("t4_no_late_write", 64'(bus.RegWrite), 64'd0);
        chk("t4_stall", 64'(bus.stall_req), 64'd0);

        // 5: fill the FIFO across pointer wrap, refuse a fifth offer, drain in order
        drvWb(1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 4; i++) begin
            drvLu(1'b1, 5'(11 + i), 32'(32'h1100 + i));
            tick();
            if (i == 2) chk("t5_ready_cnt3", 64'(bus.lu_ready), 64'd1);
        end
        chk("t5_ready_full", 64'(bus.lu_ready), 64'd0);
        chk("t5_busy_full", 64'(bus.busy_mask), 64'h7800);
        chk("t5_stall", 64'(bus.stall_req), 64'd1);
        drvWb(1'b0, '0, '0);
        drvLu(1'b1, 5'd15, 32'hF00);
        tick();
        drvLu(1'b0, '0, '0);
        chk("t5_ready_after_pop", 64'(bus.lu_ready), 64'd1);
        chk("t5_stall_clr", 64'(bus.stall_req), 64'd0);
        chk("t5_busy_after_pop", 64'(bus.busy_mask), 64'h7000);
        chk("t5_pop0_reg", 64'(bus.WriteReg), 64'd11);
        chk("t5_pop0_data", 64'(bus.WriteData), 64'h1100);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t5_pop_we", 64'(bus.RegWrite), 64'd1);
            chk("t5_pop_reg", 64'(bus.WriteReg), 64'(11 + i));
            chk("t5_pop_data", 64'(bus.WriteData), 64'(32'h1100 + i));
        end
        tick();
        chk("t5_no_fifth", 64'(bus.RegWrite), 64'd0);
        chk("t5_busy_empty", 64'(bus.busy_mask), 64'd0);

        // 6a: register 0 is never written nor queued
        drvWb(1'b1, 5'd0, 32'hFFFF);
        drvLu(1'b1, 5'd0, 32'h77);
        tick();
        drvWb(1'b0, '0, '0);
        drvLu(1'b0, '0, '0);
        chk("t6_r0_nowrite", 64'(bus.RegWrite), 64'd0);
        chk("t6_r0_busy", 64'(bus.busy_mask), 64'd0);
        chk("t6_r0_hold", 64'(bus.WriteReg), 64'd14);
        tick();
        chk("t6_r0_nopop", 64'(bus.RegWrite), 64'd0);

        // 6b: reset with three entries queued
        drvWb(1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 3; i++) begin
            drvLu(1'b1, 5'(20 + i), 32'(32'h2000 + i));
            tick();
        end
        chk("t6_busy_queued", 64'(bus.busy_mask), 64'h0070_0000);
        chk("t6_stall_pre", 64'(bus.stall_req), 64'd0);
        drvWb(1'b0, '0, '0);
        drvLu(1'b0, '0, '0);
        rst = 1'b1;
        tick();
        chk("t6_rst_we", 64'(bus.RegWrite), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy_mask), 64'd0);
        chk("t6_rst_reg", 64'(bus.WriteReg), 64'd0);
        chk("t6_rst_data", 64'(bus.WriteData), 64'd0);
        chk("t6_rst_ready", 64'(bus.lu_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("t6_post_we", 64'(bus.RegWrite), 64'd0);
        chk("t6_post_ready", 64'(bus.lu_ready), 64'd1);
        chk("t6_post_busy", 64'(bus.busy_mask), 64'd0);
        tick();
        chk("t6_post_we2", 64'(bus.RegWrite), 64'd0);
        chk("t6_post_stall", 64'(bus.stall_req), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
